eth_tx_wb_buffer: RTL

- Wishbone slave frame buffer and transmit sequencer. Sits directly downstream of the frame-loading Wishbone master.
- Collects payload bytes and a length, then, on a send command, streams preamble, SFD and payload to the MAC/PHY byte serializer.
- Payload bytes beyond the written count are zero-padded.

---
 rtl/eth_tx_wb_buffer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/eth_tx_wb_buffer.sv
// Wishbone-loaded transmit frame buffer: collects payload bytes and a length, then streams
// preamble, SFD and zero-padded payload to a byte serializer over a valid/ready handshake.
module eth_tx_wb_buffer #(
    parameter int unsigned AW           = 8,
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter int unsigned IFG_CYCLES   = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_wb_cyc,
    input  logic       i_wb_stb,
    input  logic       i_wb_we,
    input  logic [1:0] i_wb_addr,
    input  logic [7:0] i_wb_data,
    output logic       o_wb_ack,
    output logic       o_wb_stall,
    output logic [7:0] o_wb_data,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    output logic       o_tx_last,
    input  logic       i_tx_ready
);
    localparam int unsigned DEPTH = 1 << AW;
    localparam int unsigned WC_W  = AW + 1;
    localparam int unsigned CNT_W = 16;

    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_LEN    = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_SEND   = 2'd3;

    localparam logic [7:0] PRE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;

    typedef enum logic [1:0] {IDLE, PRE, PAY, IFG} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [7:0]       tx_data_next;
    logic             tx_valid_next, tx_last_next;

    logic [7:0]       mem [DEPTH];
    logic [AW-1:0]    rd_addr;
    logic [7:0]       rd_data;

    logic [WC_W-1:0]  wcount;
    logic [7:0]       len;
    logic             done, overrun;

    logic             busy, bus_req, full;
    logic             data_wr, len_wr, send_req, ovr_set, status_rd;
    logic             ifg_done, advance;
    logic [7:0]       rdata;

    assign o_wb_stall = 1'b0;
    assign busy       = (state != IDLE);
    assign full       = (wcount == WC_W'(DEPTH));

    // Bus decode, side-effect qualifiers and read mux
    always_comb begin
        bus_req   = i_wb_cyc && i_wb_stb;
        data_wr   = bus_req && i_wb_we && (i_wb_addr == A_DATA) && !busy && !full;
        len_wr    = bus_req && i_wb_we && (i_wb_addr == A_LEN) && !busy;
        send_req  = bus_req && i_wb_we && (i_wb_addr == A_SEND) && !busy;
        ovr_set   = bus_req && i_wb_we && (i_wb_addr != A_STATUS)
                    && (busy || ((i_wb_addr == A_DATA) && full));
        status_rd = bus_req && !i_wb_we && (i_wb_addr == A_STATUS);
        rdata     = 8'h00;
        if (bus_req && !i_wb_we) begin
            case (i_wb_addr)
                A_LEN:    rdata = len;
                A_STATUS: rdata = {5'b0, overrun, done, busy};
                default:  rdata = 8'h00;
            endcase
        end
    end

    // Bus registers; a flag set in the same cycle as a status read wins over the clear
    always_ff @(posedge clk) begin
        if (rst) begin
            o_wb_ack  <= 1'b0;
            o_wb_data <= 8'h00;
            wcount    <= '0;
            len       <= 8'h00;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            o_wb_ack  <= bus_req;
            o_wb_data <= rdata;
            if (ifg_done) begin
                wcount <= '0;
            end else if (data_wr) begin
                wcount <= wcount + WC_W'(1);
            end
            if (len_wr) begin
                len <= i_wb_data;
            end
            if (ifg_done) begin
                done <= 1'b1;
            end else if (status_rd) begin
                done <= 1'b0;
            end
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (status_rd) begin
                overrun <= 1'b0;
            end
        end
    end

    // Payload RAM; the read port is aimed at the next index so data is ready when loaded
    always_ff @(posedge clk) begin
        if (data_wr) begin
            mem[wcount[AW-1:0]] <= i_wb_data;
        end
        rd_data <= mem[rd_addr];
    end

    assign rd_addr = (state_next == PAY) ? AW'(cnt_next) : '0;

    // Sequencer: cnt indexes the next beat to load into the output register
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        tx_data_next  = o_tx_data;
        tx_valid_next = o_tx_valid;
        tx_last_next  = o_tx_last;
        ifg_done      = 1'b0;
        advance       = !o_tx_valid || i_tx_ready;
        case (state)
            IDLE: begin
                if (send_req) begin
                    state_next = PRE;
                    cnt_next   = '0;
                end
            end
            PRE: begin
                if (advance) begin
                    tx_valid_next = 1'b1;
                    tx_last_next  = 1'b0;
                    if (cnt == CNT_W'(PREAMBLE_LEN)) begin
                        tx_data_next = SFD_BYTE;
                        state_next   = PAY;
                        cnt_next     = '0;
                    end else begin
                        tx_data_next = PRE_BYTE;
                        cnt_next     = cnt + CNT_W'(1);
                    end
                end
            end
            PAY: begin
                if (o_tx_valid && o_tx_last) begin
                    if (i_tx_ready) begin
                        tx_valid_next = 1'b0;
                        tx_last_next  = 1'b0;
                        tx_data_next  = 8'h00;
                        state_next    = IFG;
                        cnt_next      = '0;
                    end
                end else if (advance) begin
                    tx_valid_next = 1'b1;
                    tx_data_next  = (cnt < CNT_W'(wcount)) ? rd_data : 8'h00;
                    tx_last_next  = (cnt == CNT_W'(len));
                    if (cnt != CNT_W'(len)) begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            IFG: begin
                if (cnt == CNT_W'(IFG_CYCLES - 1)) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    ifg_done   = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            o_tx_data  <= 8'h00;
            o_tx_valid <= 1'b0;
            o_tx_last  <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            o_tx_data  <= tx_data_next;
            o_tx_valid <= tx_valid_next;
            o_tx_last  <= tx_last_next;
        end
    end
endmodule
